// File: rtl/calc_pkg.sv
// Shared definitions for the hex calculator: key codes, FSM state encodings
// and the push-button priority encoder.
package calc_pkg;

    localparam int          NKEYS   = 21;
    localparam logic [4:0]  KEY_EQ  = 5'd16;
    localparam logic [4:0]  KEY_BS  = 5'd17;
    localparam logic [4:0]  KEY_SUB = 5'd18;
    localparam logic [4:0]  KEY_ADD = 5'd19;
    localparam logic [4:0]  KEY_MUL = 5'd20;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPERAND = 2'd1,
        RESULT  = 2'd2
    } calc_state_t;

    typedef enum logic {
        SCAN_PRESS   = 1'b0,
        SCAN_RELEASE = 1'b1
    } scan_state_t;

    // Highest set button index wins.
    function automatic logic [4:0] encode_key(input logic [NKEYS-1:0] buttons);
        logic [4:0] k;
        k = 5'd0;
        for (int i = 0; i < NKEYS; i++) begin
            if (buttons[i]) k = 5'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/calc_keyscan.sv
// Push-button debouncer and encoder. Emits a one-cycle strobe once any
// button has been held for DEBOUNCE cycles, then re-arms only after all
// buttons have been released for DEBOUNCE cycles.
//
// state        | meaning
// SCAN_PRESS   | armed, counting consecutive cycles with a button down
// SCAN_RELEASE | key accepted (or just out of reset), counting idle cycles
module calc_keyscan
    import calc_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic [NKEYS-1:0] pb,
    output logic             key_stb,
    output logic [4:0]       key
);

    localparam logic [7:0] CNT_LOAD = 8'(DEBOUNCE - 1);

    scan_state_t state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        stb_nx;
    logic [4:0]  key_nx;
    logic        any_down;

    assign any_down = |pb;

    // State, debounce counter and registered strobe/key.
    always_ff @(posedge hz100) begin
        if (!reset) begin
            state   <= SCAN_RELEASE;
            cnt     <= CNT_LOAD;
            key_stb <= 1'b0;
            key     <= 5'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            key_stb <= stb_nx;
            key     <= key_nx;
        end
    end

    // Down-counter restarts on any bounce; terminal count advances the state.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stb_nx   = 1'b0;
        key_nx   = key;
        case (state)
            SCAN_PRESS: begin
                if (!any_down) begin
                    cnt_nx = CNT_LOAD;
                end else if (cnt == 8'd0) begin
                    stb_nx   = 1'b1;
                    key_nx   = encode_key(pb);
                    state_nx = SCAN_RELEASE;
                    cnt_nx   = CNT_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            SCAN_RELEASE: begin
                if (any_down) begin
                    cnt_nx = CNT_LOAD;
                end else if (cnt == 8'd0) begin
                    state_nx = SCAN_PRESS;
                    cnt_nx   = CNT_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = SCAN_RELEASE;
                cnt_nx   = CNT_LOAD;
            end
        endcase
    end

endmodule

// File: rtl/calc_core.sv
// Hex-entry calculator core. Optional multiplier enabled by CALC_MUL_EN;
// without it key 20 is treated as a no-op.
//
// state   | meaning
// ENTRY   | user is typing digits into entry
// OPERAND | operator just pressed; saved holds the running result
// RESULT  | equals just pressed; saved holds the result
module calc_core
    import calc_pkg::*;
#(
    parameter int NDIGITS  = 8,
    parameter int DEBOUNCE = 2
) (
    input  logic                 hz100,
    input  logic                 reset,
    input  logic [NKEYS-1:0]     pb,
    output logic [4*NDIGITS-1:0] value,
    output logic                 disp_saved,
    output logic [4:0]           op,
    output logic                 ovf,
    output logic                 key_stb,
    output logic [4:0]           key
);

    localparam int W = 4 * NDIGITS;
`ifdef CALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    calc_state_t state, state_nx;
    logic [W-1:0] entry, entry_nx;
    logic [W-1:0] saved, saved_nx;
    logic [4:0]   op_nx;
    logic         ovf_nx;
    logic         disp_nx;

    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] nextresult;
    logic         next_ovf;
    logic         is_oper;

    calc_keyscan #(.DEBOUNCE(DEBOUNCE)) u_keyscan (
        .hz100   (hz100),
        .reset   (reset),
        .pb      (pb),
        .key_stb (key_stb),
        .key     (key)
    );

    assign value = disp_saved ? saved : entry;
    assign sum   = {1'b0, saved} + {1'b0, entry};
    assign diff  = {1'b0, saved} - {1'b0, entry};

`ifdef CALC_MUL_EN
    logic [2*W-1:0] prod;
    assign prod = {{W{1'b0}}, saved} * {{W{1'b0}}, entry};
`endif

    // Result of applying the pending op, with its overflow condition.
    always_comb begin
        nextresult = entry;
        next_ovf   = 1'b0;
        case (op)
            KEY_ADD: begin
                nextresult = sum[W-1:0];
                next_ovf   = sum[W];
            end
            KEY_SUB: begin
                nextresult = diff[W-1:0];
                next_ovf   = diff[W];
            end
`ifdef CALC_MUL_EN
            KEY_MUL: begin
                nextresult = prod[W-1:0];
                next_ovf   = |prod[2*W-1:W];
            end
`endif
            default: ;
        endcase
    end

    assign is_oper = (key == KEY_SUB) || (key == KEY_ADD) ||
                     (MUL_EN && (key == KEY_MUL));

    // Calculator registers; reset dominates a simultaneous key strobe.
    always_ff @(posedge hz100) begin
        if (!reset) begin
            state      <= ENTRY;
            entry      <= '0;
            saved      <= '0;
            op         <= 5'd0;
            ovf        <= 1'b0;
            disp_saved <= 1'b0;
        end else begin
            state      <= state_nx;
            entry      <= entry_nx;
            saved      <= saved_nx;
            op         <= op_nx;
            ovf        <= ovf_nx;
            disp_saved <= disp_nx;
        end
    end

    // Key dispatch: next state and register updates on an accepted key.
    always_comb begin
        state_nx = state;
        entry_nx = entry;
        saved_nx = saved;
        op_nx    = op;
        ovf_nx   = ovf;
        disp_nx  = disp_saved;
        if (key_stb) begin
            if (!key[4]) begin
                if (state == RESULT) begin
                    entry_nx = {{(W-4){1'b0}}, key[3:0]};
                    saved_nx = '0;
                    op_nx    = 5'd0;
                    ovf_nx   = 1'b0;
                end else if (entry[W-1:W-4] == 4'd0) begin
                    entry_nx = {entry[W-5:0], key[3:0]};
                end
                state_nx = ENTRY;
                disp_nx  = 1'b0;
            end else if (key == KEY_BS) begin
                if (state == ENTRY) entry_nx = entry >> 4;
            end else if (key == KEY_EQ) begin
                saved_nx = nextresult;
                ovf_nx   = ovf | next_ovf;
                disp_nx  = 1'b1;
                state_nx = RESULT;
            end else if (is_oper) begin
                op_nx = key;
                case (state)
                    ENTRY: begin
                        saved_nx = nextresult;
                        ovf_nx   = ovf | next_ovf;
                        entry_nx = '0;
                        disp_nx  = 1'b1;
                        state_nx = OPERAND;
                    end
                    RESULT: begin
                        entry_nx = '0;
                        state_nx = OPERAND;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_core.sv
// Directed self-checking bench for calc_core (NDIGITS=8, DEBOUNCE=2).
// Exercises the multiplier path when built with CALC_MUL_EN.
module tb_calc_core;
    import calc_pkg::*;

    localparam int W  = 32;
    localparam int DB = 2;

    logic             hz100 = 1'b0;
    logic             reset = 1'b0;
    logic [NKEYS-1:0] pb    = '0;
    logic [W-1:0]     value;
    logic             disp_saved;
    logic [4:0]       op;
    logic             ovf;
    logic             key_stb;
    logic [4:0]       key;

    always #5 hz100 = ~hz100;

    calc_core #(.NDIGITS(8), .DEBOUNCE(DB)) dut (
        .hz100      (hz100),
        .reset      (reset),
        .pb         (pb),
        .value      (value),
        .disp_saved (disp_saved),
        .op         (op),
        .ovf        (ovf),
        .key_stb    (key_stb),
        .key        (key)
    );

    typedef struct packed {
        logic [31:0] val;
        logic        disp;
        logic [4:0]  op;
        logic        ovf;
    } exp_t;

    exp_t        sbq[$];
    int          checks    = 0;
    int          errors    = 0;
    int          stb_count = 0;
    logic [4:0]  last_key  = 5'd0;
    int          base;
    bit          seen;
    logic [31:0] acc;

    always @(negedge hz100) begin
        if (key_stb) begin
            stb_count++;
            last_key = key;
        end
    end

    function automatic exp_t mk(input logic [31:0] v, input logic d,
                                input logic [4:0] o, input logic f);
        exp_t e;
        e.val  = v;
        e.disp = d;
        e.op   = o;
        e.ovf  = f;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge hz100);
        reset = 1'b0;
        pb    = '0;
        repeat (3) @(negedge hz100);
        reset = 1'b1;
        repeat (DB + 2) @(negedge hz100);
    endtask

    // Press one key until accepted, then check the calculator outputs one
    // cycle later against the expectation queued at stimulus time.
    task automatic press(input string tag, input int code, input exp_t e);
        exp_t want;
        bit   got_stb;
        logic [NKEYS-1:0] one;
        got_stb = 1'b0;
        one = 21'd1;
        sbq.push_back(e);
        @(negedge hz100);
        pb = one << code;
        for (int i = 0; i < 20 && !got_stb; i++) begin
            @(negedge hz100);
            if (key_stb) got_stb = 1'b1;
        end
        chk({tag, ":strobe"}, 32'(got_stb), 32'd1);
        if (got_stb) chk({tag, ":key"}, 32'(key), 32'(code));
        @(negedge hz100);
        want = sbq.pop_front();
        chk({tag, ":value"}, value, want.val);
        chk({tag, ":disp"}, 32'(disp_saved), 32'(want.disp));
        chk({tag, ":op"}, 32'(op), 32'(want.op));
        chk({tag, ":ovf"}, 32'(ovf), 32'(want.ovf));
        pb = '0;
        repeat (DB + 2) @(negedge hz100);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge hz100);
        chk("rst:value", value, 32'd0);
        chk("rst:disp", 32'(disp_saved), 32'd0);
        chk("rst:op", 32'(op), 32'd0);
        chk("rst:ovf", 32'(ovf), 32'd0);
        chk("rst:key_stb", 32'(key_stb), 32'd0);
        chk("rst:key", 32'(key), 32'd0);
        reset = 1'b1;
        repeat (DB + 2) @(negedge hz100);

        // 12 + 3 = 0x15
        press("t1_d1", 1, mk(32'h1, 0, 5'd0, 0));
        press("t1_d2", 2, mk(32'h12, 0, 5'd0, 0));
        press("t1_add", 19, mk(32'h12, 1, 5'd19, 0));
        press("t1_d3", 3, mk(32'h3, 0, 5'd19, 0));
        press("t1_eq", 16, mk(32'h15, 1, 5'd19, 0));

        // digit after result starts fresh; buffer full; backspace
        press("t2_d1", 1, mk(32'h1, 0, 5'd0, 0));
        acc = 32'h1;
        for (int d = 2; d <= 8; d++) begin
            acc = {acc[27:0], 4'(d)};
            press("t2_dig", d, mk(acc, 0, 5'd0, 0));
        end
        press("t2_full", 9, mk(32'h12345678, 0, 5'd0, 0));
        press("t2_bs", 17, mk(32'h01234567, 0, 5'd0, 0));

        // add carry sets ovf; digit after result clears it
        do_reset();
        acc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            acc = {acc[27:0], 4'hF};
            press("t3_f", 15, mk(acc, 0, 5'd0, 0));
        end
        press("t3_add", 19, mk(32'hFFFFFFFF, 1, 5'd19, 0));
        press("t3_d1", 1, mk(32'h1, 0, 5'd19, 0));
        press("t3_eq", 16, mk(32'h0, 1, 5'd19, 1));
        press("t3_d5", 5, mk(32'h5, 0, 5'd0, 0));

        // subtract borrow; repeated equals re-applies op
        do_reset();
        press("t4_d2", 2, mk(32'h2, 0, 5'd0, 0));
        press("t4_sub", 18, mk(32'h2, 1, 5'd18, 0));
        press("t4_d5", 5, mk(32'h5, 0, 5'd18, 0));
        press("t4_eq1", 16, mk(32'hFFFFFFFD, 1, 5'd18, 1));
        press("t4_eq2", 16, mk(32'hFFFFFFF8, 1, 5'd18, 1));

        // op replacement in OPERAND, operator and backspace in RESULT
        do_reset();
        press("t5_d7", 7, mk(32'h7, 0, 5'd0, 0));
        press("t5_add", 19, mk(32'h7, 1, 5'd19, 0));
        press("t5_sub", 18, mk(32'h7, 1, 5'd18, 0));
        press("t5_d2", 2, mk(32'h2, 0, 5'd18, 0));
        press("t5_eq", 16, mk(32'h5, 1, 5'd18, 0));
        press("t5_add2", 19, mk(32'h5, 1, 5'd19, 0));
        press("t5_d1", 1, mk(32'h1, 0, 5'd19, 0));
        press("t5_eq2", 16, mk(32'h6, 1, 5'd19, 0));
        press("t5_bs", 17, mk(32'h6, 1, 5'd19, 0));

        // multiply key
        do_reset();
`ifdef CALC_MUL_EN
        press("t6_d1", 1, mk(32'h1, 0, 5'd0, 0));
        acc = 32'h1;
        for (int i = 0; i < 4; i++) begin
            acc = {acc[27:0], 4'h0};
            press("t6_d0", 0, mk(acc, 0, 5'd0, 0));
        end
        press("t6_mul", 20, mk(32'h10000, 1, 5'd20, 0));
        press("t6_e1", 1, mk(32'h1, 0, 5'd20, 0));
        acc = 32'h1;
        for (int i = 0; i < 4; i++) begin
            acc = {acc[27:0], 4'h0};
            press("t6_e0", 0, mk(acc, 0, 5'd20, 0));
        end
        press("t6_eq", 16, mk(32'h0, 1, 5'd20, 1));
        press("t6_d3", 3, mk(32'h3, 0, 5'd0, 0));
        press("t6_mul2", 20, mk(32'h3, 1, 5'd20, 0));
        press("t6_d5", 5, mk(32'h5, 0, 5'd20, 0));
        press("t6_eq2", 16, mk(32'hF, 1, 5'd20, 0));
`else
        press("t6_d3", 3, mk(32'h3, 0, 5'd0, 0));
        press("t6_mul_ign", 20, mk(32'h3, 0, 5'd0, 0));
        press("t6_eq", 16, mk(32'h3, 1, 5'd0, 0));
`endif

        // debounce: 1-cycle glitch is rejected, 3-cycle hold accepted once
        do_reset();
        base = stb_count;
        @(negedge hz100) pb = 21'h80;
        @(negedge hz100) pb = '0;
        repeat (3) @(negedge hz100);
        pb = 21'h80;
        repeat (3) @(negedge hz100);
        pb = '0;
        repeat (4) @(negedge hz100);
        chk("db:count", 32'(stb_count - base), 32'd1);
        chk("db:key", 32'(last_key), 32'd7);

        // a short release bounce does not re-arm the scanner
        base = stb_count;
        pb = 21'h200;
        repeat (3) @(negedge hz100);
        pb = '0;
        @(negedge hz100);
        pb = 21'h200;
        repeat (4) @(negedge hz100);
        chk("bounce:count", 32'(stb_count - base), 32'd1);
        pb = '0;
        repeat (4) @(negedge hz100);
        pb = 21'h200;
        repeat (3) @(negedge hz100);
        pb = '0;
        repeat (4) @(negedge hz100);
        chk("rearm:count", 32'(stb_count - base), 32'd2);
        chk("rearm:key", 32'(last_key), 32'd9);

        // reset wins over a coincident strobe; key held across reset is ignored
        do_reset();
        press("rp_d5", 5, mk(32'h5, 0, 5'd0, 0));
        @(negedge hz100);
        pb = 21'h40;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge hz100);
            if (key_stb) seen = 1'b1;
        end
        chk("rp:strobe", 32'(seen), 32'd1);
        reset = 1'b0;
        @(negedge hz100);
        chk("rp:value", value, 32'd0);
        chk("rp:key_stb", 32'(key_stb), 32'd0);
        @(negedge hz100);
        reset = 1'b1;
        base = stb_count;
        repeat (8) @(negedge hz100);
        chk("hold:count", 32'(stb_count - base), 32'd0);
        chk("hold:value", value, 32'd0);
        pb = '0;
        repeat (DB + 2) @(negedge hz100);
        press("hold:after", 6, mk(32'h6, 0, 5'd0, 0));

        chk("sb:empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
